grn_node_lut: RTL and testbench

GRN_NODE_LUT -- requirements
Module: grn_node_lut

---
 rtl/grn_node_lut_pkg.sv | 18 +
 rtl/grn_node_lut_copy.sv | 75 +++++++
 rtl/grn_node_lut.sv | 60 ++++++
 tb/tb_grn_node_lut.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/grn_node_lut_pkg.sv
// Shared constants and helpers for the gene-regulatory-network node LUT.
// Holds the default parameter values and the saturating counter increment.
package grn_node_lut_pkg;

  localparam int GRN_K_DEF        = 4;
  localparam int GRN_NCOPY_DEF    = 2;
  localparam int GRN_CW_DEF       = 8;
  localparam int GRN_STABLE_N_DEF = 4;

  // Increment v, clamped at max; callers resize to their own counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    if (v >= max) begin
      return max;
    end
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/grn_node_lut_copy.sv
// One independent state copy of the node: state bit, skip alternation,
// saturating change counter and the unchanged-run tracker behind stable.
module grn_node_lut_copy
  import grn_node_lut_pkg::*;
#(
  parameter int   CW       = GRN_CW_DEF,
  parameter int   STABLE_N = GRN_STABLE_N_DEF,
  parameter logic SKIP     = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reset_nos,
  input  logic          init_state,
  input  logic          start,
  input  logic          next_val,
  output logic          s,
  output logic [CW-1:0] chg_cnt,
  output logic          stable
);

  localparam logic [31:0] CNT_MAX = (CW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CW) - 32'd1);

  logic          s_reg;
  logic          pass_reg;
  logic [CW-1:0] chg_cnt_reg;
  logic [CW-1:0] run_reg;
  logic          stable_reg;

  logic [CW-1:0] chg_cnt_next;
  logic [CW-1:0] run_next;

  always_comb begin
    chg_cnt_next = CW'(sat_inc(32'(chg_cnt_reg), CNT_MAX));
    run_next     = CW'(sat_inc(32'(run_reg), 32'(STABLE_N)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg       <= 1'b0;
      pass_reg    <= 1'b0;
      chg_cnt_reg <= '0;
      run_reg     <= '0;
      stable_reg  <= 1'b0;
    end else if (reset_nos) begin
      s_reg       <= init_state;
      pass_reg    <= 1'b1;
      chg_cnt_reg <= '0;
      run_reg     <= '0;
      stable_reg  <= 1'b0;
    end else if (start) begin
      if (SKIP && !pass_reg) begin
        // Skipped strobe only arms the next one.
        pass_reg <= 1'b1;
      end else begin
        if (SKIP) begin
          pass_reg <= 1'b0;
        end
        if (next_val != s_reg) begin
          s_reg       <= next_val;
          chg_cnt_reg <= chg_cnt_next;
          run_reg     <= '0;
          stable_reg  <= 1'b0;
        end else begin
          run_reg    <= run_next;
          stable_reg <= (run_next == CW'(STABLE_N));
        end
      end
    end
  end

  assign s       = s_reg;
  assign chg_cnt = chg_cnt_reg;
  assign stable  = stable_reg;

endmodule

// File: rtl/grn_node_lut.sv
// Boolean network node: one shared truth table evaluated by NCOPY
// independent state copies, each with its own regulator inputs and strobe.
module grn_node_lut
  import grn_node_lut_pkg::*;
#(
  parameter int               K         = GRN_K_DEF,
  parameter int               NCOPY     = GRN_NCOPY_DEF,
  parameter int               CW        = GRN_CW_DEF,
  parameter int               STABLE_N  = GRN_STABLE_N_DEF,
  parameter logic [NCOPY-1:0] SKIP_MASK = NCOPY'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reset_nos,
  input  logic [NCOPY-1:0]      init_state,
  input  logic [NCOPY-1:0]      start_s,
  input  logic [NCOPY*K-1:0]    in_s,
  input  logic                  cfg_we,
  input  logic [(2**K)-1:0]     cfg_lut,
  output logic [NCOPY-1:0]      s,
  output logic [NCOPY*CW-1:0]   chg_cnt,
  output logic [NCOPY-1:0]      stable
);

  logic [(2**K)-1:0] lut_reg;
  logic [NCOPY-1:0]  next_val;

  // Table write is independent of the update priority; copies see the old
  // table in the cycle it is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_reg <= '0;
    end else if (cfg_we) begin
      lut_reg <= cfg_lut;
    end
  end

  generate
    for (genvar gi = 0; gi < NCOPY; gi++) begin : g_copy
      assign next_val[gi] = lut_reg[in_s[gi*K +: K]];

      grn_node_lut_copy #(
        .CW       (CW),
        .STABLE_N (STABLE_N),
        .SKIP     (SKIP_MASK[gi])
      ) u_copy (
        .clk        (clk),
        .rst        (rst),
        .reset_nos  (reset_nos),
        .init_state (init_state[gi]),
        .start      (start_s[gi]),
        .next_val   (next_val[gi]),
        .s          (s[gi]),
        .chg_cnt    (chg_cnt[gi*CW +: CW]),
        .stable     (stable[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_grn_node_lut.sv
// Directed bench for grn_node_lut: default instance plus a CW=2 instance
// sharing the same stimulus for counter saturation.
module tb_grn_node_lut;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reset_nos = 1'b0;
  logic [1:0]  init_state = 2'b00;
  logic [1:0]  start_s = 2'b00;
  logic [7:0]  in_s = 8'h00;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_lut = 16'h0000;

  logic [1:0]  s;
  logic [15:0] chg_cnt;
  logic [1:0]  stable;
  logic [1:0]  s2;
  logic [3:0]  chg_cnt2;
  logic [1:0]  stable2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  grn_node_lut dut (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
    .start_s(start_s), .in_s(in_s), .cfg_we(cfg_we), .cfg_lut(cfg_lut),
    .s(s), .chg_cnt(chg_cnt), .stable(stable)
  );

  grn_node_lut #(.CW(2), .STABLE_N(3)) dut_cw2 (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
    .start_s(start_s), .in_s(in_s), .cfg_we(cfg_we), .cfg_lut(cfg_lut),
    .s(s2), .chg_cnt(chg_cnt2), .stable(stable2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge with the currently driven inputs, then release the strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0; reset_nos = 1'b0; start_s = 2'b00; cfg_we = 1'b0;
  endtask

  task automatic load_lut(input logic [15:0] v);
    cfg_lut = v; cfg_we = 1'b1;
    tick();
  endtask

  task automatic renos(input logic [1:0] init);
    init_state = init; reset_nos = 1'b1;
    tick();
  endtask

  task automatic strobe(input logic [1:0] st, input logic [7:0] in);
    start_s = st; in_s = in;
    tick();
  endtask

  initial begin
    logic [3:0] in33 [4];
    logic       exp33 [4];
    in33  = '{4'h1, 4'h0, 4'h0, 4'h1};
    exp33 = '{1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rst_s", 32'(s), 32'h0);
    chk("rst_chg", 32'(chg_cnt), 32'h0);
    chk("rst_stable", 32'(stable), 32'h0);

    // Skip copy has pass=0 after rst: first strobe is skipped
    load_lut(16'hFFFF);
    strobe(2'b01, 8'h00);
    chk("prenos_skip_s", 32'(s), 32'h0);
    strobe(2'b01, 8'h00);
    chk("prenos_second_s", 32'(s), 32'h1);

    // AND4 on copy1
    load_lut(16'h8000);
    renos(2'b00);
    chk("nos_s", 32'(s), 32'h0);
    chk("nos_chg", 32'(chg_cnt), 32'h0);
    strobe(2'b10, 8'hF0);
    chk("and4_s1", 32'(s[1]), 32'h1);
    chk("and4_chg1", 32'(chg_cnt[15:8]), 32'h1);
    chk("and4_s0_hold", 32'(s[0]), 32'h0);

    // Alternation on skip copy0, LUT = in[0]
    load_lut(16'hAAAA);
    renos(2'b00);
    for (int i = 0; i < 4; i++) begin
      strobe(2'b01, {4'h0, in33[i]});
      chk($sformatf("skip_s0_%0d", i + 1), 32'(s[0]), 32'(exp33[i]));
    end
    chk("skip_chg0", 32'(chg_cnt[7:0]), 32'h2);

    // Stability on copy1 with all-ones LUT
    load_lut(16'hFFFF);
    renos(2'b10);
    for (int i = 0; i < 4; i++) begin
      strobe(2'b10, 8'h30);
      chk($sformatf("stable1_%0d", i + 1), 32'(stable[1]), (i == 3) ? 32'h1 : 32'h0);
    end
    load_lut(16'h0000);
    strobe(2'b10, 8'h30);
    chk("unstable_s1", 32'(s[1]), 32'h0);
    chk("unstable_flag", 32'(stable[1]), 32'h0);
    chk("unstable_chg1", 32'(chg_cnt[15:8]), 32'h1);

    // Same-cycle cfg_we uses old LUT (all zeros), next strobe uses new
    cfg_lut = 16'hFFFF; cfg_we = 1'b1;
    strobe(2'b10, 8'h50);
    chk("cfg_old_s1", 32'(s[1]), 32'h0);
    strobe(2'b10, 8'h50);
    chk("cfg_new_s1", 32'(s[1]), 32'h1);

    // Toggle copy1 six times with LUT = NOT(in[0])
    load_lut(16'h5555);
    renos(2'b00);
    for (int i = 0; i < 6; i++) begin
      strobe(2'b10, {3'b000, 1'(i % 2), 4'h0});
      chk($sformatf("tog_s1_%0d", i + 1), 32'(s2[1]), 32'((i + 1) % 2));
      chk($sformatf("sat_chg1_%0d", i + 1), 32'(chg_cnt2[3:2]), (i < 3) ? 32'(i + 1) : 32'h3);
      chk($sformatf("wide_chg1_%0d", i + 1), 32'(chg_cnt[15:8]), 32'(i + 1));
    end

    // rst beats reset_nos, start_s and cfg_we
    rst = 1'b1; reset_nos = 1'b1; init_state = 2'b11; start_s = 2'b11;
    in_s = 8'hFF; cfg_we = 1'b1; cfg_lut = 16'hFFFF;
    tick();
    chk("rst_all_s", 32'(s), 32'h0);
    chk("rst_all_chg", 32'(chg_cnt), 32'h0);
    chk("rst_all_stable", 32'(stable), 32'h0);
    chk("rst_all_chg2", 32'(chg_cnt2), 32'h0);
    renos(2'b11);
    chk("post_rst_nos_s", 32'(s), 32'h3);
    strobe(2'b10, 8'hF0);
    chk("post_rst_lut0_s1", 32'(s[1]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
